// File: rtl/regfile_arbiter.sv
// Two-port register-file arbiter (core port 0, debug port 1) with a background
// scan engine that reads out every register pair while sharing slots with port 0.
module regfile_arbiter #(
  parameter int unsigned SCAN_LAST = 15
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [1:0]  be0,
  input  logic [1:0]  be1,
  input  logic [9:0]  addr0,
  input  logic [9:0]  addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  input  logic        scan_start,
  output logic        scan_busy,
  output logic        scan_valid,
  output logic [3:0]  scan_index,
  output logic [15:0] scan_data,
  output logic        scan_done,
  output logic [1:0]  rf_wr_en,
  output logic [1:0]  rf_rd_en,
  output logic [9:0]  rf_wr_addr,
  output logic [9:0]  rf_rd_addr,
  output logic [15:0] rf_data_in,
  input  logic [15:0] rf_data_out
);

  localparam logic [3:0] LAST_K = 4'(SCAN_LAST);

  typedef enum logic {IDLE, SCAN} state_e;
  typedef enum logic [1:0] {SRC_NONE, SRC_P0, SRC_P1, SRC_SCAN} src_e;

  state_e      state_q, state_d;
  src_e        pend_q, pend_d;
  logic [3:0]  scan_k_q, scan_k_d;
  logic [3:0]  pend_idx_q, pend_idx_d;
  logic [1:0]  pend_be_q, pend_be_d;
  logic        prio1_q, prio1_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [15:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        scan_busy_q, scan_busy_d, scan_valid_q, scan_valid_d;
  logic        scan_done_q, scan_done_d;
  logic [3:0]  scan_index_q, scan_index_d;
  logic [15:0] scan_data_q, scan_data_d;
  logic [1:0]  rf_wr_en_q, rf_wr_en_d, rf_rd_en_q, rf_rd_en_d;
  logic [9:0]  rf_wr_addr_q, rf_wr_addr_d, rf_rd_addr_q, rf_rd_addr_d;
  logic [15:0] rf_data_in_q, rf_data_in_d;

  logic scan_accept, elig0, elig1, grant0, grant1;

  function automatic logic [15:0] lane_mask(input logic [15:0] d, input logic [1:0] be);
    return d & {{8{be[1]}}, {8{be[0]}}};
  endfunction

  // A held request is invisible for one cycle after its ack, so it cannot issue twice.
  // Port 1 stays off the bus from scan acceptance until the final scan read has returned.
  assign scan_accept = (state_q == IDLE) && scan_start;
  assign elig0  = req0 && !ack0_q;
  assign elig1  = req1 && !ack1_q && (state_q == IDLE) && !scan_accept && (pend_q != SRC_SCAN);
  assign grant0 = elig0 && (!elig1 || !prio1_q);
  assign grant1 = elig1 && !grant0;

  always_comb begin
    // NOTE: every _d gets a default here so no path leaves a value unassigned (no latches).
    state_d      = state_q;
    scan_k_d     = scan_k_q;
    prio1_d      = prio1_q;
    pend_d       = SRC_NONE;
    pend_be_d    = pend_be_q;
    pend_idx_d   = pend_idx_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    scan_valid_d = 1'b0;
    scan_done_d  = 1'b0;
    scan_index_d = scan_index_q;
    scan_data_d  = scan_data_q;
    rf_wr_en_d   = 2'b00;
    rf_rd_en_d   = 2'b00;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_rd_addr_d = rf_rd_addr_q;
    rf_data_in_d = rf_data_in_q;

    // Return data for the read issued on the previous edge.
    unique case (pend_q)
      SRC_P0: begin
        rvalid0_d = 1'b1;
        rdata0_d  = lane_mask(rf_data_out, pend_be_q);
      end
      SRC_P1: begin
        rvalid1_d = 1'b1;
        rdata1_d  = lane_mask(rf_data_out, pend_be_q);
      end
      SRC_SCAN: begin
        scan_valid_d = 1'b1;
        scan_index_d = pend_idx_q;
        scan_data_d  = rf_data_out;
        scan_done_d  = (pend_idx_q == LAST_K);
      end
      default: ;
    endcase

    if (grant0) begin
      ack0_d  = 1'b1;
      prio1_d = 1'b1;
      if (we0) begin
        rf_wr_en_d   = be0;
        rf_wr_addr_d = addr0;
        rf_data_in_d = wdata0;
      end else begin
        rf_rd_en_d   = be0;
        rf_rd_addr_d = addr0;
        pend_d       = SRC_P0;
        pend_be_d    = be0;
      end
    end else if (grant1) begin
      ack1_d  = 1'b1;
      prio1_d = 1'b0;
      if (we1) begin
        rf_wr_en_d   = be1;
        rf_wr_addr_d = addr1;
        rf_data_in_d = wdata1;
      end else begin
        rf_rd_en_d   = be1;
        rf_rd_addr_d = addr1;
        pend_d       = SRC_P1;
        pend_be_d    = be1;
      end
    end else if (state_q == SCAN) begin
      rf_rd_en_d   = 2'b11;
      rf_rd_addr_d = {scan_k_q, 1'b1, scan_k_q, 1'b0};
      pend_d       = SRC_SCAN;
      pend_idx_d   = scan_k_q;
      if (scan_k_q == LAST_K) begin
        state_d  = IDLE;
        scan_k_d = '0;
      end else begin
        scan_k_d = scan_k_q + 4'd1;
      end
    end

    if (scan_accept) begin
      state_d  = SCAN;
      scan_k_d = '0;
    end

    scan_busy_d = (state_d == SCAN) || (pend_d == SRC_SCAN) || scan_done_d;
  end

  always_ff @(posedge clock) begin
    // NOTE: reset clears every flop, including the pending-read tracker, so a read or
    // scan in flight at reset never produces a late rvalid/scan_valid.
    if (!nreset) begin
      state_q      <= IDLE;
      pend_q       <= SRC_NONE;
      scan_k_q     <= '0;
      pend_idx_q   <= '0;
      pend_be_q    <= '0;
      prio1_q      <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      scan_busy_q  <= 1'b0;
      scan_valid_q <= 1'b0;
      scan_done_q  <= 1'b0;
      scan_index_q <= '0;
      scan_data_q  <= '0;
      rf_wr_en_q   <= '0;
      rf_rd_en_q   <= '0;
      rf_wr_addr_q <= '0;
      rf_rd_addr_q <= '0;
      rf_data_in_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
      state_q      <= state_d;
      pend_q       <= pend_d;
      scan_k_q     <= scan_k_d;
      pend_idx_q   <= pend_idx_d;
      pend_be_q    <= pend_be_d;
      prio1_q      <= prio1_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      scan_busy_q  <= scan_busy_d;
      scan_valid_q <= scan_valid_d;
      scan_done_q  <= scan_done_d;
      scan_index_q <= scan_index_d;
      scan_data_q  <= scan_data_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      rf_data_in_q <= rf_data_in_d;
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign rvalid0    = rvalid0_q;
  assign rvalid1    = rvalid1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign scan_busy  = scan_busy_q;
  assign scan_valid = scan_valid_q;
  assign scan_index = scan_index_q;
  assign scan_data  = scan_data_q;
  assign scan_done  = scan_done_q;
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_rd_en   = rf_rd_en_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_rd_addr = rf_rd_addr_q;
  assign rf_data_in = rf_data_in_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter: a behavioural model predicts grants and read
// results from the arbitration rules; a separate monitor matches returned data.
module tb_regfile_arbiter;

  localparam int SCAN_LAST = 15;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [1:0]  be0 = '0, be1 = '0;
  logic [9:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        scan_start = 1'b0;
  logic        ack0, ack1, rvalid0, rvalid1, scan_busy, scan_valid, scan_done;
  logic [15:0] rdata0, rdata1, scan_data, rf_data_in;
  logic [15:0] rf_data_out = '0;
  logic [3:0]  scan_index;
  logic [1:0]  rf_wr_en, rf_rd_en;
  logic [9:0]  rf_wr_addr, rf_rd_addr;

  regfile_arbiter #(.SCAN_LAST(SCAN_LAST)) dut (
    .clock(clock), .nreset(nreset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .be0(be0), .be1(be1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_valid(scan_valid),
    .scan_index(scan_index), .scan_data(scan_data), .scan_done(scan_done),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_wr_addr(rf_wr_addr),
    .rf_rd_addr(rf_rd_addr), .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int scan_cnt = 0;
  int done_cnt = 0;

  typedef struct {logic [15:0] data; int due;} rd_exp_t;
  typedef struct {logic [3:0] idx; logic [15:0] data; int due;} scan_exp_t;
  typedef struct packed {
    logic nreset, scan_start, req0, we0; logic [1:0] be0; logic [9:0] addr0; logic [15:0] wdata0;
    logic req1, we1; logic [1:0] be1; logic [9:0] addr1; logic [15:0] wdata1;
  } snap_t;

  rd_exp_t   q0[$], q1[$];
  scan_exp_t qs[$];

  logic [7:0] rf_mem [32] = '{default: 8'h00};
  logic [7:0] m_mem  [32] = '{default: 8'h00};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // External register file: 32 byte registers, writes and reads settle at the negedge.
  initial forever begin
    @(negedge clock);
    if (rf_wr_en[0]) rf_mem[rf_wr_addr[4:0]] = rf_data_in[7:0];
    if (rf_wr_en[1]) rf_mem[rf_wr_addr[9:5]] = rf_data_in[15:8];
    if (rf_rd_en != 2'b00) rf_data_out = {rf_mem[rf_rd_addr[9:5]], rf_mem[rf_rd_addr[4:0]]};
    else                   rf_data_out = 16'($urandom);
  end

  // Reference model for a granted port transaction at the current edge.
  task automatic model_port(input int p, input logic we, input logic [1:0] be,
                            input logic [9:0] addr, input logic [15:0] wd);
    logic [15:0] exp;
    if (we) begin
      check("wr_en", rf_wr_en, be);
      check("wr_addr", rf_wr_addr, addr);
      check("wr_data", rf_data_in, wd);
      check("wr_rd_en", rf_rd_en, 0);
      if (be[0]) m_mem[addr[4:0]] = wd[7:0];
      if (be[1]) m_mem[addr[9:5]] = wd[15:8];
    end else begin
      check("rd_en", rf_rd_en, be);
      check("rd_addr", rf_rd_addr, addr);
      check("rd_wr_en", rf_wr_en, 0);
      exp = {be[1] ? m_mem[addr[9:5]] : 8'h00, be[0] ? m_mem[addr[4:0]] : 8'h00};
      if (p == 0) q0.push_back('{data: exp, due: cyc + 1});
      else        q1.push_back('{data: exp, due: cyc + 1});
    end
  endtask

  // Model: decides from the inputs seen at each edge who should have been granted.
  initial begin : model
    snap_t s;
    logic  m_scan, m_fav1, m_ack0, m_ack1, m_last;
    logic  accept, e0, e1, g0, g1, siss, last, exp_busy;
    int    m_k, lo, hi;
    s = '0; m_scan = 0; m_fav1 = 0; m_ack0 = 0; m_ack1 = 0; m_last = 0; m_k = 0;
    forever begin
      @(negedge clock);
      if (!s.nreset) begin
        check("rst_port_out", {ack0, ack1, rvalid0, rvalid1, rdata0, rdata1}, 0);
        check("rst_scan_out", {scan_busy, scan_valid, scan_index, scan_data, scan_done}, 0);
        check("rst_rf_out", {rf_wr_en, rf_rd_en, rf_wr_addr, rf_rd_addr, rf_data_in}, 0);
        m_scan = 0; m_fav1 = 0; m_ack0 = 0; m_ack1 = 0; m_last = 0; m_k = 0;
      end else begin
        accept = s.scan_start && !m_scan;
        e0 = s.req0 && !m_ack0;
        e1 = s.req1 && !m_ack1 && !m_scan && !accept && !m_last;
        g0 = e0 && (!e1 || !m_fav1);
        g1 = e1 && !g0;
        siss = m_scan && !g0;
        check("ack0", ack0, g0);
        check("ack1", ack1, g1);
        last = 1'b0;
        if (g0)      model_port(0, s.we0, s.be0, s.addr0, s.wdata0);
        else if (g1) model_port(1, s.we1, s.be1, s.addr1, s.wdata1);
        else if (siss) begin
          lo = 2 * m_k;
          hi = lo + 1;
          check("scan_rd_en", rf_rd_en, 2'b11);
          check("scan_rd_addr", rf_rd_addr, hi * 32 + lo);
          check("scan_wr_en", rf_wr_en, 0);
          qs.push_back('{idx: 4'(m_k), data: {m_mem[hi], m_mem[lo]}, due: cyc + 1});
          last = (m_k == SCAN_LAST);
          m_k  = last ? 0 : m_k + 1;
          if (last) m_scan = 0;
        end else begin
          check("idle_wr_en", rf_wr_en, 0);
          check("idle_rd_en", rf_rd_en, 0);
        end
        exp_busy = accept || m_scan || siss || m_last;
        check("scan_busy", scan_busy, exp_busy);
        if (accept) begin
          m_scan = 1;
          m_k    = 0;
        end
        m_last = last;
        if (g0)      m_fav1 = 1;
        else if (g1) m_fav1 = 0;
        m_ack0 = g0;
        m_ack1 = g1;
      end
      s = {nreset, scan_start, req0, we0, be0, addr0, wdata0, req1, we1, be1, addr1, wdata1};
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents returned data.
  initial begin : monitor
    logic      rst_prev;
    rd_exp_t   h;
    scan_exp_t hs;
    rst_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!rst_prev) begin
        q0.delete(); q1.delete(); qs.delete();
      end else begin
        if (rvalid0) begin
          if (q0.size() == 0) check("rvalid0_unexpected", rvalid0, 0);
          else begin
            h = q0.pop_front();
            check("rvalid0_latency", cyc, h.due);
            check("rdata0", rdata0, h.data);
          end
        end else if (q0.size() != 0 && q0[0].due <= cyc) begin
          check("rvalid0_missing", rvalid0, 1);
          void'(q0.pop_front());
        end
        if (rvalid1) begin
          if (q1.size() == 0) check("rvalid1_unexpected", rvalid1, 0);
          else begin
            h = q1.pop_front();
            check("rvalid1_latency", cyc, h.due);
            check("rdata1", rdata1, h.data);
          end
        end else if (q1.size() != 0 && q1[0].due <= cyc) begin
          check("rvalid1_missing", rvalid1, 1);
          void'(q1.pop_front());
        end
        if (scan_valid) begin
          scan_cnt++;
          if (scan_done) done_cnt++;
          if (qs.size() == 0) check("scan_valid_unexpected", scan_valid, 0);
          else begin
            hs = qs.pop_front();
            check("scan_latency", cyc, hs.due);
            check("scan_index", scan_index, hs.idx);
            check("scan_data", scan_data, hs.data);
            check("scan_done", scan_done, hs.idx == 4'(SCAN_LAST));
          end
        end else begin
          if (scan_done) check("scan_done_alone", scan_done, 0);
          if (qs.size() != 0 && qs[0].due <= cyc) begin
            check("scan_valid_missing", scan_valid, 1);
            void'(qs.pop_front());
          end
        end
      end
      rst_prev = nreset;
    end
  end

  task automatic port_txn(input int p, input logic we, input logic [1:0] be,
                          input logic [9:0] addr, input logic [15:0] wd);
    logic got;
    if (p == 0) begin req0 = 1'b1; we0 = we; be0 = be; addr0 = addr; wdata0 = wd; end
    else        begin req1 = 1'b1; we1 = we; be1 = be; addr1 = addr; wdata1 = wd; end
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clock);
      got = (p == 0) ? ack0 : ack1;
    end
    if (!got) check("ack_timeout", got, 1);
    @(posedge clock); #1;
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  task automatic scan_pulse();
    scan_start = 1'b1;
    @(posedge clock); #1;
    scan_start = 1'b0;
  endtask

  task automatic wait_scan_idle();
    logic busy;
    busy = 1'b1;
    for (int n = 0; n < 500 && busy; n++) begin
      @(negedge clock);
      busy = scan_busy;
    end
    if (busy) check("scan_idle_timeout", busy, 0);
    @(posedge clock); #1;
  endtask

  task automatic rand_port(input int p, input int n);
    logic [4:0] lo, hi;
    for (int i = 0; i < n; i++) begin
      lo = 5'($urandom_range(0, 31));
      hi = 5'((32'(lo) + 1 + $urandom_range(0, 30)) % 32);
      port_txn(p, 1'($urandom), 2'($urandom), {hi, lo}, 16'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int base_s, base_d;
    logic seen;
    repeat (3) @(posedge clock);
    #1 nreset = 1'b1;

    // Write then read back a full word; then a low-lane-only read of a mixed pair.
    port_txn(0, 1'b1, 2'b11, {5'd3, 5'd2}, 16'hBEEF);
    port_txn(0, 1'b0, 2'b11, {5'd3, 5'd2}, 16'h0000);
    port_txn(0, 1'b1, 2'b11, {5'd7, 5'd6}, 16'hAA55);
    port_txn(0, 1'b0, 2'b01, {5'd7, 5'd6}, 16'h0000);
    port_txn(1, 1'b0, 2'b00, {5'd7, 5'd6}, 16'h0000);

    // Both ports contending with held reads.
    fork
      begin
        port_txn(0, 1'b0, 2'b11, {5'd3, 5'd2}, 16'h0);
        port_txn(0, 1'b0, 2'b10, {5'd7, 5'd6}, 16'h0);
      end
      begin
        port_txn(1, 1'b0, 2'b11, {5'd7, 5'd6}, 16'h0);
        port_txn(1, 1'b0, 2'b01, {5'd3, 5'd2}, 16'h0);
      end
    join

    // Load reg r with r+1, then scan with port 0 busy and port 1 held off.
    for (int k = 0; k < 16; k++)
      port_txn(0, 1'b1, 2'b11, {5'(2 * k + 1), 5'(2 * k)}, {8'(2 * k + 2), 8'(2 * k + 1)});
    base_s = scan_cnt;
    base_d = done_cnt;
    fork
      scan_pulse();
      port_txn(1, 1'b0, 2'b11, {5'd9, 5'd8}, 16'h0);
      for (int i = 0; i < 8; i++) port_txn(0, 1'b0, 2'b11, {5'(i + 1), 5'(i)}, 16'h0);
    join
    wait_scan_idle();
    check("scan_count", scan_cnt - base_s, 16);
    check("scan_done_count", done_cnt - base_d, 1);

    // Reset in the middle of a scan, then a fresh scan from pair 0.
    scan_pulse();
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clock);
      seen = scan_valid && (scan_index == 4'd4);
    end
    if (!seen) check("scan_k4_timeout", seen, 1);
    @(posedge clock); #1 nreset = 1'b0;
    @(posedge clock); #1 nreset = 1'b1;
    base_d = done_cnt;
    repeat (6) @(posedge clock);
    #1;
    check("no_done_after_abort", done_cnt - base_d, 0);
    base_s = scan_cnt;
    scan_pulse();
    wait_scan_idle();
    check("rescan_count", scan_cnt - base_s, 16);

    // Randomised traffic on both ports with scans (including an ignored re-start).
    fork
      rand_port(0, 60);
      rand_port(1, 60);
      for (int i = 0; i < 3; i++) begin
        repeat ($urandom_range(20, 80)) @(posedge clock);
        #1;
        scan_pulse();
        repeat (5) @(posedge clock);
        #1;
        scan_pulse();
      end
    join
    repeat (60) @(posedge clock);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter: SCAN_LAST, default 15, index of the last register pair visited by a scan (pair k = registers 2k, 2k+1).
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 nreset  input  1  reset, synchronous, active-low.
REQ-004 req0 / req1  input  1  access request, port 0 (core) / port 1 (debug); held with payload until ack.
REQ-005 we0 / we1  input  1  1 = write, 0 = read.
REQ-006 be0 / be1  input  2  lane enables; bit0 = low lane, bit1 = high lane.
REQ-007 addr0 / addr1  input  10  {high-lane reg[9:5], low-lane reg[4:0]}.
REQ-008 wdata0 / wdata1  input  16  write data {high byte, low byte}.
REQ-009 ack0 / ack1  output  1  one-cycle pulse: transaction issued.
REQ-010 rvalid0 / rvalid1  output  1  one-cycle pulse: rdata0 / rdata1 valid.
REQ-011 rdata0 / rdata1  output  16  read data; disabled lanes read 0x00.
REQ-012 scan_start  input  1  pulse: start full register scan.
REQ-013 scan_busy  output  1  scan in progress.
REQ-014 scan_valid  output  1  one-cycle pulse: scan_index/scan_data valid.
REQ-015 scan_index  output  4  pair index k of scan_data.
REQ-016 scan_data  output  16  {reg[2k+1], reg[2k]}.
REQ-017 scan_done  output  1  one-cycle pulse coincident with last scan_valid.
REQ-018 rf_wr_en, rf_rd_en  output  2 each  register-file lane enables.
REQ-019 rf_wr_addr, rf_rd_addr  output  10 each  register-file addresses.
REQ-020 rf_data_in  output  16  register-file write data.
REQ-021 rf_data_out  input  16  register-file read data (valid after negedge following issue).

Function
REQ-022 All rf_* outputs, ack*, rvalid*, rdata*, scan_* outputs shall be registered.
REQ-023 At most one transaction shall issue per clock; issue at edge T drives rf_* and ackX high for the cycle T..T+1.
REQ-024 Write issue: rf_wr_en = beX, rf_wr_addr = addrX, rf_data_in = wdataX, rf_rd_en = 00.
REQ-025 Read issue: rf_rd_en = beX, rf_rd_addr = addrX, rf_wr_en = 00.
REQ-026 Read data shall be sampled from rf_data_out at edge T+1 and presented on rdataX with rvalidX high for cycle T+1..T+2 (latency: rvalid one cycle after ack).
REQ-027 Cycles with no issue shall drive rf_wr_en = rf_rd_en = 00; addresses and rf_data_in hold last value.
REQ-028 be = 00 shall still be acked; read returns rvalid with 0x0000; no register changes.
REQ-029 reqX shall be ignored in the cycle following ackX (prevents double issue of held request).
REQ-030 Both requesting, not scanning: round-robin; grant the port not granted most recently; after reset port 0 wins first tie.
REQ-031 Single requester eligible: granted immediately, no idle cycle.
REQ-032 FSM states IDLE, SCAN. IDLE -> SCAN on scan_start; SCAN -> IDLE at edge issuing pair SCAN_LAST.
REQ-033 scan_start while SCAN shall be ignored.
REQ-034 In SCAN: port 1 never granted; port 0 has priority; scan read of pair k (rf_rd_en = 11, lo = 2k, hi = 2k+1) issues only in cycles with no port-0 issue.
REQ-035 Scan counter k starts 0, increments by 1 per scan issue, never wraps past SCAN_LAST.
REQ-036 scan_valid/scan_index/scan_data appear one cycle after each scan issue; scan_done with k = SCAN_LAST.
REQ-037 scan_busy high from edge accepting scan_start through the cycle carrying scan_done.
REQ-038 Port-1 request pending at scan end shall be granted in the first eligible cycle after scan_busy falls.

Reset
REQ-039 nreset = 0 at an edge: FSM IDLE, k = 0, round-robin favours port 0, all outputs 0 (rf addresses/data 0).
REQ-040 Reset mid-scan or mid-read shall abort: no subsequent rvalid, scan_valid or scan_done.

Verification
REQ-041 Port 0 write be=11 addr {5'd3,5'd2} data 0xBEEF, then read same -> ack0, one cycle later rvalid0 with rdata0 = 0xBEEF.
REQ-042 req0 and req1 both held high with reads for 4 grants -> ack order 0,1,0,1; no back-to-back acks to one port.
REQ-043 Read be=01 of reg holding 0xAA/0x55 pair -> rdata = 0x0055.
REQ-044 Load regs r = r+1, scan_start, req0 pulsed every other cycle -> 16 scan_valid, index 0..15, data {2k+2,2k+1}, scan_done on index 15, port 1 held off throughout.
REQ-045 nreset low during scan at k = 5 -> all outputs 0 next cycle, scan_busy 0, no scan_done; new scan restarts at k = 0.
